// File: rtl/dct_da_mac.sv
// Bit-serial distributed-arithmetic multiply-accumulate for the DCT datapath.
// Four signed samples are walked MSB first, one bit slice per cycle. Each slice
// addresses an external coefficient ROM, and the returned word is shift-accumulated
// into y = sum_k c * x_k.
module dct_da_mac #(
   parameter int unsigned IN_W  = 9,
   parameter int unsigned ROM_W = 17,
   parameter int unsigned ACC_W = 26
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [IN_W-1:0]         x0,
   input  logic [IN_W-1:0]         x1,
   input  logic [IN_W-1:0]         x2,
   input  logic [IN_W-1:0]         x3,
   output logic                    rom_cs,
   output logic [3:0]              rom_addr,
   input  logic [ROM_W-1:0]        rom_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [ACC_W-1:0]        y
);

   localparam int unsigned IDX_W = (IN_W > 1) ? $clog2(IN_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(IN_W - 1);

   // A narrower accumulator would silently wrap on worst-case inputs.
   if (ACC_W < ROM_W + IN_W) begin : g_acc_w_check
      $error("dct_da_mac: ACC_W must be at least ROM_W + IN_W");
   end

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e                 state_q, state_d;
   logic [IN_W-1:0]        x0_q, x0_d;
   logic [IN_W-1:0]        x1_q, x1_d;
   logic [IN_W-1:0]        x2_q, x2_d;
   logic [IN_W-1:0]        x3_q, x3_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0]       y_q, y_d;
   logic                   in_ready_q, in_ready_d;
   logic                   out_valid_q, out_valid_d;
   logic                   rom_cs_q, rom_cs_d;

   logic signed [ACC_W-1:0] rom_ext;
   logic signed [ACC_W-1:0] acc_nxt;

   assign rom_ext = {{(ACC_W - ROM_W){rom_data[ROM_W-1]}}, rom_data};

   // ROM address is the current bit slice of the latched samples, only while computing.
   always_comb begin
      rom_addr = 4'b0000;
      if (state_q == StCalc) begin
         rom_addr = {x3_q[idx_q], x2_q[idx_q], x1_q[idx_q], x0_q[idx_q]};
      end
   end

   // Next-state logic: handshake, bit-serial accumulation and result hold.
   always_comb begin
      state_d     = state_q;
      x0_d        = x0_q;
      x1_d        = x1_q;
      x2_d        = x2_q;
      x3_d        = x3_q;
      idx_d       = idx_q;
      acc_d       = acc_q;
      y_d         = y_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      rom_cs_d    = rom_cs_q;
      acc_nxt     = acc_q;

      unique case (state_q)
         StIdle: begin
            if (in_valid) begin
               x0_d       = x0;
               x1_d       = x1;
               x2_d       = x2;
               x3_d       = x3;
               idx_d      = IDX_TOP;
               acc_d      = '0;
               in_ready_d = 1'b0;
               rom_cs_d   = 1'b1;
               state_d    = StCalc;
            end
         end
         StCalc: begin
            // The MSB slice carries negative weight in two's complement.
            if (idx_q == IDX_TOP) begin
               acc_nxt = -rom_ext;
            end else begin
               acc_nxt = (acc_q <<< 1) + rom_ext;
            end
            acc_d = acc_nxt;
            idx_d = idx_q - 1'b1;
            if (idx_q == '0) begin
               y_d         = acc_nxt;
               idx_d       = IDX_TOP;
               rom_cs_d    = 1'b0;
               out_valid_d = 1'b1;
               state_d     = StDone;
            end
         end
         StDone: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            rom_cs_d    = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset discards any transform in progress.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         x0_q        <= '0;
         x1_q        <= '0;
         x2_q        <= '0;
         x3_q        <= '0;
         idx_q       <= IDX_TOP;
         acc_q       <= '0;
         y_q         <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         rom_cs_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         x0_q        <= x0_d;
         x1_q        <= x1_d;
         x2_q        <= x2_d;
         x3_q        <= x3_d;
         idx_q       <= idx_d;
         acc_q       <= acc_d;
         y_q         <= y_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         rom_cs_q    <= rom_cs_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign rom_cs    = rom_cs_q;
   assign y         = y_q;

endmodule

// File: tb/tb_dct_da_mac.sv
// Self-checking bench for dct_da_mac with a c4 coefficient ROM model and a
// result scoreboard fed at input handshakes and drained at output handshakes.
module tb_dct_da_mac;

   localparam int unsigned IN_W  = 9;
   localparam int unsigned ROM_W = 17;
   localparam int unsigned ACC_W = 26;

   logic              clk;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [IN_W-1:0]   x0, x1, x2, x3;
   logic              rom_cs;
   logic [3:0]        rom_addr;
   logic [ROM_W-1:0]  rom_data;
   logic              out_valid;
   logic              out_ready;
   logic [ACC_W-1:0]  y;

   int checks;
   int failures;
   longint sb[$];
   logic [3:0] tr_addr [0:8];
   logic       tr_cs   [0:8];

   dct_da_mac #(
      .IN_W (IN_W),
      .ROM_W(ROM_W),
      .ACC_W(ACC_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .x0       (x0),
      .x1       (x1),
      .x2       (x2),
      .x3       (x3),
      .rom_cs   (rom_cs),
      .rom_addr (rom_addr),
      .rom_data (rom_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .y        (y)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // c4 ROM: entry = round(cos(pi/4) * 2^14) * popcount(addr)
   always_comb rom_data = 17'(11585 * $countones(rom_addr));

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint model(input logic [8:0] a, input logic [8:0] b,
                                    input logic [8:0] c, input logic [8:0] d);
      return 64'sd11585 * (longint'($signed(a)) + longint'($signed(b)) +
                           longint'($signed(c)) + longint'($signed(d)));
   endfunction

   // Scoreboard: push at input handshake, pop and compare at output handshake.
   always @(negedge clk) begin
      if (rst_n) begin
         if (in_valid && in_ready) sb.push_back(model(x0, x1, x2, x3));
         if (out_valid && out_ready) begin
            if (sb.size() == 0) check("sb_underflow", 1, 0);
            else check("y", longint'($signed(y)), sb.pop_front());
         end
      end
   end

   // One transform: accept, scramble inputs, trace the CALC slices, land in DONE.
   task automatic xfer(input logic [8:0] a, input logic [8:0] b,
                       input logic [8:0] c, input logic [8:0] d);
      logic ok;
      int   n;
      x0 = a; x1 = b; x2 = c; x3 = d;
      in_valid = 1'b1;
      n = 0;
      ok = 1'b0;
      while (!ok && n < 40) begin
         ok = in_ready;
         @(posedge clk); #1;
         n++;
      end
      if (!ok) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      x0 = 9'($urandom); x1 = 9'($urandom); x2 = 9'($urandom); x3 = 9'($urandom);
      for (int i = 0; i < 9; i++) begin
         tr_addr[i] = rom_addr;
         tr_cs[i]   = rom_cs;
         if (i == 8) check("ov_early", longint'(out_valid), 0);
         @(posedge clk); #1;
      end
      check("ov_latency", longint'(out_valid), 1);
   endtask

   initial begin
      int   last;
      int   rises;
      logic prev_ov;
      checks = 0; failures = 0;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      x0 = '0; x1 = '0; x2 = '0; x3 = '0;
      #12;
      check("rst_in_ready", longint'(in_ready), 1);
      check("rst_out_valid", longint'(out_valid), 0);
      check("rst_rom_cs", longint'(rom_cs), 0);
      check("rst_rom_addr", longint'(rom_addr), 0);
      check("rst_y", longint'(y), 0);
      #12 rst_n = 1'b1;
      @(posedge clk); #1;

      // x0 = 1: only the LSB slice addresses entry 1
      xfer(9'd1, 9'd0, 9'd0, 9'd0);
      for (int i = 0; i < 9; i++) begin
         check("trace_cs", longint'(tr_cs[i]), 1);
         check("trace_addr", longint'(tr_addr[i]), (i == 8) ? 1 : 0);
      end
      @(posedge clk); #1;
      check("idle_after", longint'(in_ready), 1);

      xfer(9'd1, 9'd1, 9'd1, 9'd1);
      @(posedge clk); #1;
      xfer(9'h1FF, 9'd0, 9'd0, 9'd0);
      check("sign_slice_addr", longint'(tr_addr[0]), 1);
      check("sign_slice_cs", longint'(tr_cs[0]), 1);
      @(posedge clk); #1;
      xfer(9'd100, 9'h1CE, 9'd7, 9'h1FF);
      @(posedge clk); #1;
      xfer(9'h100, 9'h100, 9'h100, 9'h100);
      @(posedge clk); #1;

      // Backpressure in DONE
      out_ready = 1'b0;
      xfer(9'd37, 9'h1F0, 9'd2, 9'd9);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1;
         x0 = 9'($urandom); x1 = 9'($urandom);
         check("bp_out_valid", longint'(out_valid), 1);
         check("bp_in_ready", longint'(in_ready), 0);
         check("bp_rom_cs", longint'(rom_cs), 0);
         check("bp_y", longint'($signed(y)), model(9'd37, 9'h1F0, 9'd2, 9'd9));
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      check("bp_release_ov", longint'(out_valid), 0);
      check("bp_release_ready", longint'(in_ready), 1);
      xfer(9'd12, 9'd0, 9'd0, 9'd0);
      @(posedge clk); #1;

      // Reset at the 4th CALC cycle
      x0 = 9'd3; x1 = 9'd0; x2 = 9'd0; x3 = 9'd0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      check("calc4_cs", longint'(rom_cs), 1);
      #1 rst_n = 1'b0;
      #1;
      check("rst_calc_ov", longint'(out_valid), 0);
      check("rst_calc_cs", longint'(rom_cs), 0);
      check("rst_calc_y", longint'(y), 0);
      check("rst_calc_ready", longint'(in_ready), 1);
      check("rst_calc_addr", longint'(rom_addr), 0);
      sb.delete();
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      xfer(9'd255, 9'd0, 9'd0, 9'd0);
      @(posedge clk); #1;

      // Reset while holding a result in DONE
      out_ready = 1'b0;
      xfer(9'd5, 9'd6, 9'd0, 9'd0);
      #2 rst_n = 1'b0;
      #1;
      check("rst_done_ov", longint'(out_valid), 0);
      check("rst_done_y", longint'(y), 0);
      sb.delete();
      rst_n = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;

      // Back-to-back with in_valid held high
      last = -1; rises = 0; prev_ov = 1'b0;
      in_valid = 1'b1;
      x0 = 9'($urandom); x1 = 9'($urandom); x2 = 9'($urandom); x3 = 9'($urandom);
      for (int c = 0; c < 50; c++) begin
         @(posedge clk); #1;
         x0 = 9'($urandom); x1 = 9'($urandom); x2 = 9'($urandom); x3 = 9'($urandom);
         if (out_valid && !prev_ov) begin
            if (last >= 0) check("b2b_period", longint'(c - last), 11);
            last = c;
            rises++;
         end
         prev_ov = out_valid;
      end
      in_valid = 1'b0;
      check("b2b_count", longint'(rises >= 4), 1);
      for (int n = 0; n < 40 && sb.size() != 0; n++) begin
         @(posedge clk); #1;
      end
      check("sb_drained", longint'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
